// File: rtl/axis_sample_packer.sv
// axis_sample_packer: packs RATIO narrow AXI-stream samples into one wide
// registered AXI-stream word. Lane 0 (the first sample of a word) sits in the
// least-significant bits.
//
// Optional feature macro: AXIS_SAMPLE_PACKER_TLAST_EN
//   When defined, s_axis_tlast / m_axis_tlast are added. A sample accepted
//   with tlast closes the word early; the unfilled upper lanes read as zero.
module axis_sample_packer #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int RATIO        = 6,
  parameter int DATA_WIDTH   = 72
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [SAMPLE_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
  input  logic                    s_axis_tlast,
`endif
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
  output logic                    m_axis_tlast,
`endif
  output logic [DATA_WIDTH-1:0]   m_axis_tdata
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // Geometry checks: the packed word must exactly hold RATIO samples.
  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("axis_sample_packer: RATIO must be >= 2");
    end
    if (DATA_WIDTH != SAMPLE_WIDTH * RATIO) begin : g_bad_width
      $error("axis_sample_packer: DATA_WIDTH must equal SAMPLE_WIDTH*RATIO");
    end
  endgenerate

  // State: lane counter, RATIO-1 accumulator lanes, output register + valid.
  logic [LANE_W-1:0]                   lane_q, lane_d;
  logic [RATIO-2:0][SAMPLE_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]               out_data_q, out_data_d;
  logic                                out_valid_q, out_valid_d;

  logic [RATIO-1:0][SAMPLE_WIDTH-1:0]  word;
  logic                                in_last;
  logic                                slot_free;
  logic                                accept;
  logic                                complete;

`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
  logic out_last_q, out_last_d;
  assign in_last      = s_axis_tlast;
  assign m_axis_tlast = out_last_q;
`else
  assign in_last = 1'b0;
`endif

  // The output slot can take a new word if it is empty or draining this cycle.
  assign slot_free = ~out_valid_q | m_axis_tready;

  // Only a word-completing sample needs the output slot; every other lane is
  // always accepted, even while the downstream FIFO is full.
  assign s_axis_tready = ((lane_q != LAST_LANE) & ~in_last) | slot_free;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign complete      = accept & ((lane_q == LAST_LANE) | in_last);

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;

  // Assemble the completed word: filled lanes from the accumulator, the
  // current sample in its lane, anything above it zero (early tlast case).
  always_comb begin
    word = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (LANE_W'(i) < lane_q) begin
        word[i] = acc_q[i];
      end
    end
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == LANE_W'(i)) begin
        word[i] = s_axis_tdata;
      end
    end
  end

  // Next-state for the lane counter and accumulator lanes.
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (accept) begin
      lane_d = complete ? '0 : lane_q + LANE_W'(1);
      for (int i = 0; i < RATIO - 1; i++) begin
        if (lane_q == LANE_W'(i)) begin
          acc_d[i] = s_axis_tdata;
        end
      end
    end
  end

  // Next-state for the output register: load wins over drain, data held
  // stable while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
  // Next-state for the output tlast flag, tied to the word it travels with.
  always_comb begin
    out_last_d = out_last_q;
    if (complete) begin
      out_last_d = s_axis_tlast;
    end
  end

  // Output tlast register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last_q <= 1'b0;
    end else begin
      out_last_q <= out_last_d;
    end
  end
`endif

  // Packer state registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_axis_sample_packer.sv
// Testbench for axis_sample_packer (default geometry 6 x 12 -> 72).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_axis_sample_packer;

  localparam int SW = 12;
  localparam int R  = 6;
  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [SW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_sample_packer #(
    .SAMPLE_WIDTH(SW),
    .RATIO       (R),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
    .s_axis_tlast (s_axis_tlast),
`endif
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
    .m_axis_tlast (m_axis_tlast),
`endif
    .m_axis_tdata (m_axis_tdata)
  );

`ifndef AXIS_SAMPLE_PACKER_TLAST_EN
  assign m_axis_tlast = 1'b0;
`endif

  // Reference packing: sample k occupies bits [(k+1)*SW-1 : k*SW]; absent lanes are zero.
  function automatic logic [DW-1:0] pack_q(input logic [SW-1:0] q[$]);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < q.size(); k++) begin
      w = w | (DW'(q[k]) << (k * SW));
    end
    return w;
  endfunction

  // Present one sample from the next falling edge and hold it until accepted.
  task automatic send(input logic [SW-1:0] v, input logic last);
    int guard;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v;
    s_axis_tlast  = last;
    #1;
    guard = 0;
    while (!s_axis_tready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: sample %h not accepted, tready=%b required 1", v, s_axis_tready);
    end
  endtask

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid);
    end
    n_cmp++;
    if (m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_tdata: got %h required 0", m_axis_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %b required 1", s_axis_tready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    logic [DW-1:0] exp_w;
    exp_w = 72'h006005004003002001;
    m_axis_tready = 1'b1;
    for (int i = 1; i <= R; i++) begin
      send(SW'(i), 1'b0);
    end
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_w) begin
      n_fail++;
      $display("FAIL single_word: got v=%b d=%h required v=1 d=%h", m_axis_tvalid, m_axis_tdata, exp_w);
    end
    @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_word_pulse: tvalid got %b required 0", m_axis_tvalid);
    end
    $display("test_single_word word=%h", exp_w);
  endtask

  task automatic test_back_to_back();
    int            first_cyc;
    int            second_cyc;
    int            nwords;
    int            ready_low;
    logic [DW-1:0] w1, w2;
    nwords = 0; ready_low = 0; first_cyc = -1; second_cyc = -1;
    w1 = '0; w2 = '0;
    m_axis_tready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        if (nwords == 0) begin first_cyc = c; w1 = m_axis_tdata; end
        else begin second_cyc = c; w2 = m_axis_tdata; end
        nwords++;
      end
      if (c <= 12) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = SW'(c);
        #1;
        if (!s_axis_tready) ready_low++;
      end else begin
        idle_inputs();
      end
    end
    n_cmp++;
    if (nwords != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words required 2", nwords);
    end
    n_cmp++;
    if (w1 !== 72'h006005004003002001 || w2 !== 72'h00C00B00A009008007) begin
      n_fail++;
      $display("FAIL b2b_data: got %h,%h required 006005004003002001,00C00B00A009008007", w1, w2);
    end
    n_cmp++;
    if (second_cyc - first_cyc != R) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", second_cyc - first_cyc, R);
    end
    n_cmp++;
    if (ready_low != 0) begin
      n_fail++;
      $display("FAIL b2b_tready: low %0d cycles required 0", ready_low);
    end
    $display("test_back_to_back words=%0d gap=%0d", nwords, second_cyc - first_cyc);
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] s[$];
    logic [SW-1:0] a[$];
    logic [SW-1:0] b[$];
    logic [DW-1:0] w1, w2;
    for (int k = 0; k < 2 * R; k++) s.push_back(SW'($urandom));
    for (int k = 0; k < R; k++) begin a.push_back(s[k]); b.push_back(s[R + k]); end
    w1 = pack_q(a);
    w2 = pack_q(b);
    m_axis_tready = 1'b0;
    for (int k = 0; k < 2 * R; k++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = s[k];
      #1;
      n_cmp++;
      if (s_axis_tready !== ((k < 2 * R - 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL bp_tready_s%0d: got %b required %b", k + 1, s_axis_tready, (k < 2 * R - 1));
      end
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== w1) begin
        n_fail++;
        $display("FAIL bp_hold: got sr=%b v=%b d=%h required sr=0 v=1 d=%h", s_axis_tready, m_axis_tvalid, m_axis_tdata, w1);
      end
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    #1;
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_tready: got %b required 1", s_axis_tready);
    end
    @(negedge clk);
    m_axis_tready = 1'b0;
    idle_inputs();
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w2) begin
      n_fail++;
      $display("FAIL bp_second_word: got v=%b d=%h required v=1 d=%h", m_axis_tvalid, m_axis_tdata, w2);
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: tvalid got %b required 0", m_axis_tvalid);
    end
    $display("test_backpressure w1=%h w2=%h", w1, w2);
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] exp_w;
    m_axis_tready = 1'b0;
    for (int k = 0; k < R + 3; k++) send(SW'(12'h201 + k), 1'b0);
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h required v=0 d=0", m_axis_tvalid, m_axis_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    for (int k = 0; k < R; k++) send(SW'(12'hA01 + k), 1'b0);
    @(negedge clk);
    idle_inputs();
    exp_w = 72'hA06A05A04A03A02A01;
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_w) begin
      n_fail++;
      $display("FAIL post_reset_word: got v=%b d=%h required v=1 d=%h", m_axis_tvalid, m_axis_tdata, exp_w);
    end
    @(negedge clk);
    $display("test_async_reset word=%h", exp_w);
  endtask

  task automatic test_random();
    logic [SW-1:0] samples[600];
    logic [SW-1:0] partial[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got, want, prev_data;
    logic          prev_stalled;
    logic          exp_ready;
    int            sent, words, cycles, ferr;
    for (int k = 0; k < 600; k++) samples[k] = SW'($urandom);
    sent = 0; words = 0; cycles = 0; ferr = 0;
    prev_stalled = 1'b0; prev_data = '0;
    while ((sent < 600 || exp_q.size() > 0) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (prev_stalled) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
          n_fail++;
          $display("FAIL rnd_stall_stable: got v=%b d=%h required v=1 d=%h", m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      s_axis_tvalid = (sent < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_axis_tdata  = (sent < 600) ? samples[sent] : '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = (partial.size() < R - 1) || !m_axis_tvalid || m_axis_tready;
      n_cmp++;
      if (s_axis_tready !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_tready: got %b required %b (lanes filled %0d)", s_axis_tready, exp_ready, partial.size());
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got = m_axis_tdata;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_unexpected_word: got %h required none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL rnd_word%0d: got %h required %h", words, got, want);
          end
        end
        words++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        partial.push_back(s_axis_tdata);
        sent++;
        if (partial.size() == R) begin
          exp_q.push_back(pack_q(partial));
          partial.delete();
        end
      end
      prev_stalled = m_axis_tvalid && !m_axis_tready;
      prev_data    = m_axis_tdata;
    end
    idle_inputs();
    m_axis_tready = 1'b1;
    if (cycles >= 20000) ferr = 1;
    n_cmp++;
    if (words != 100 || ferr != 0) begin
      n_fail++;
      $display("FAIL rnd_total: got %0d words (timeout=%0d) required 100", words, ferr);
    end
    @(negedge clk);
    $display("test_random samples=%0d words=%0d cycles=%0d", sent, words, cycles);
  endtask

`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
  task automatic test_tlast();
    logic [SW-1:0] q[$];
    logic [DW-1:0] exp_w;
    m_axis_tready = 1'b1;
    send(12'h001, 1'b0);
    send(12'h002, 1'b0);
    send(12'h003, 1'b1);
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 72'h000000000003002001 || m_axis_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL tlast_word: got v=%b d=%h l=%b required v=1 d=000000000003002001 l=1", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    for (int k = 0; k < R; k++) begin
      q.push_back(SW'(12'h0B1 + k));
      send(SW'(12'h0B1 + k), 1'b0);
    end
    @(negedge clk);
    idle_inputs();
    exp_w = pack_q(q);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_w || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL tlast_next_lane0: got v=%b d=%h l=%b required v=1 d=%h l=0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_w);
    end
    @(negedge clk);
    $display("test_tlast done");
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_random();
`ifdef AXIS_SAMPLE_PACKER_TLAST_EN
    test_tlast();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
